uart_frame_arbiter: RTL and testbench

- Shares one byte-level uart_tx instance (tx_data / tx_req / tx_done handshake) between 4 independent report sources.
- Round-robin arbitration across sources; the winner's payload is latched in one transfer.
- Each frame is emitted as "&&" + payload + "&&", matching the team's string framing.
- Sits between the measurement/report logic and the UART byte transmitter on the FPGA side.

---
 rtl/uart_frame_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_frame_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_arbiter
// Function : round-robin sharing of one byte uart_tx among 4 report sources;
//            each frame is "&&" payload "&&". Option: UART_ARB_SRC_TAG_EN
//            inserts an ASCII source tag after the header.
// Revision : 1.0
// ============================================================================
module uart_frame_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [NUM_SRC-1:0]             src_req,
    input  logic [NUM_SRC*8*MAX_BYTES-1:0] src_payload,
    input  logic [NUM_SRC*LEN_W-1:0]       src_length,
    output logic [NUM_SRC-1:0]             src_ack,
    output logic [NUM_SRC-1:0]             src_done,
    output logic                           busy,
    output logic [7:0]                     byte_tx_data,
    output logic                           byte_tx_req,
    input  logic                           byte_tx_done
);

    localparam int               PL_W      = 8 * MAX_BYTES;
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [7:0]       c_AMP     = 8'h26;
    localparam logic [7:0]       c_TAG_BASE = 8'h30;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR1 = 3'd1;
    localparam logic [2:0] c_HDR2 = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
    localparam logic [2:0] c_TRL1 = 3'd4;
    localparam logic [2:0] c_TRL2 = 3'd5;
    localparam logic [2:0] c_FIN  = 3'd6;
`ifdef UART_ARB_SRC_TAG_EN
    localparam logic [2:0] c_TAG  = 3'd7;
`endif

    logic [2:0]       state_q,   state_d;
    logic [1:0]       rr_ptr_q,  rr_ptr_d;
    logic [1:0]       id_q,      id_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] cnt_q,     cnt_d;
    logic [PL_W-1:0]  payload_q, payload_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_req_q,  tx_req_d;
    logic [NUM_SRC-1:0] ack_q,   ack_d;
    logic [NUM_SRC-1:0] done_q,  done_d;

    logic             w_win_vld;
    logic [1:0]       w_win_id;
    logic [PL_W-1:0]  w_win_payload;
    logic [LEN_W-1:0] w_win_len;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [2:0]       w_body_state;
    logic [7:0]       w_body_data;

    function automatic logic [7:0] pick_byte(input logic [PL_W-1:0] pl,
                                             input logic [LEN_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (LEN_W'(i) == idx) begin
                b = pl[i*8 +: 8];
            end
        end
        return b;
    endfunction

    // Search starts one past the last winner, wrapping modulo 4.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = rr_ptr_q;
        for (int off = 1; off <= NUM_SRC; off++) begin
            if (!w_win_vld && src_req[rr_ptr_q + 2'(off)]) begin
                w_win_vld = 1'b1;
                w_win_id  = rr_ptr_q + 2'(off);
            end
        end
    end

    always_comb begin
        w_win_payload = '0;
        w_win_len     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (2'(s) == w_win_id) begin
                w_win_payload = src_payload[s*PL_W +: PL_W];
                w_win_len     = src_length[s*LEN_W +: LEN_W];
            end
        end
    end

    assign w_cnt_inc    = cnt_q + LEN_W'(1);
    assign w_body_state = (len_q != '0) ? c_DATA : c_TRL1;
    assign w_body_data  = (len_q != '0) ? payload_q[7:0] : c_AMP;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        tx_data_d = tx_data_q;
        tx_req_d  = 1'b0;
        ack_d     = '0;
        done_d    = '0;

        case (state_q)
            c_IDLE: begin
                if (w_win_vld) begin
                    id_d          = w_win_id;
                    rr_ptr_d      = w_win_id;
                    payload_d     = w_win_payload;
                    len_d         = (w_win_len > c_MAX_LEN) ? c_MAX_LEN : w_win_len;
                    cnt_d         = '0;
                    ack_d[w_win_id] = 1'b1;
                    tx_req_d      = 1'b1;
                    tx_data_d     = c_AMP;
                    state_d       = c_HDR1;
                end
            end
            c_HDR1: begin
                if (byte_tx_done) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = c_AMP;
                    state_d   = c_HDR2;
                end
            end
            c_HDR2: begin
                if (byte_tx_done) begin
                    tx_req_d  = 1'b1;
`ifdef UART_ARB_SRC_TAG_EN
                    tx_data_d = c_TAG_BASE + {6'b0, id_q};
                    state_d   = c_TAG;
`else
                    tx_data_d = w_body_data;
                    state_d   = w_body_state;
`endif
                end
            end
`ifdef UART_ARB_SRC_TAG_EN
            c_TAG: begin
                if (byte_tx_done) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = w_body_data;
                    state_d   = w_body_state;
                end
            end
`endif
            c_DATA: begin
                if (byte_tx_done) begin
                    tx_req_d = 1'b1;
                    if (w_cnt_inc == len_q) begin
                        tx_data_d = c_AMP;
                        state_d   = c_TRL1;
                    end else begin
                        cnt_d     = w_cnt_inc;
                        tx_data_d = pick_byte(payload_q, w_cnt_inc);
                    end
                end
            end
            c_TRL1: begin
                if (byte_tx_done) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = c_AMP;
                    state_d   = c_TRL2;
                end
            end
            c_TRL2: begin
                if (byte_tx_done) begin
                    done_d[id_q] = 1'b1;
                    state_d      = c_FIN;
                end
            end
            c_FIN: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= c_IDLE;
            rr_ptr_q  <= 2'd3;
            id_q      <= 2'd0;
            len_q     <= '0;
            cnt_q     <= '0;
            payload_q <= '0;
            tx_data_q <= 8'h00;
            tx_req_q  <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign src_ack      = ack_q;
    assign src_done     = done_q;
    assign busy         = (state_q != c_IDLE);
    assign byte_tx_data = tx_data_q;
    assign byte_tx_req  = tx_req_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_arbiter.sv
`default_nettype none
// tb_uart_frame_arbiter: directed and randomized checks of uart_frame_arbiter
// against a frame-level reference model (byte queue per granted frame).
module tb_uart_frame_arbiter;

`ifdef UART_ARB_SRC_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [3:0]   src_req = '0;
    logic [255:0] src_payload = '0;
    logic [15:0]  src_length = '0;
    logic [3:0]   src_ack;
    logic [3:0]   src_done;
    logic         busy;
    logic [7:0]   byte_tx_data;
    logic         byte_tx_req;
    logic         byte_tx_done = 1'b0;

    uart_frame_arbiter #(.NUM_SRC(4), .MAX_BYTES(8), .LEN_W(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .src_req      (src_req),
        .src_payload  (src_payload),
        .src_length   (src_length),
        .src_ack      (src_ack),
        .src_done     (src_done),
        .busy         (busy),
        .byte_tx_data (byte_tx_data),
        .byte_tx_req  (byte_tx_req),
        .byte_tx_done (byte_tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view (idle / sending a byte queue / finish)
    logic [3:0] exp_ack = '0, exp_done = '0;
    logic       exp_req = 1'b0, exp_busy = 1'b0;
    logic [7:0] exp_data = 8'h00;
    int         m_phase = 0;
    int         m_rr = 3;
    int         m_id = 0;
    int         m_sent = 0;
    bq_t        m_q;

    initial begin
        int c, n;
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_phase = 0; m_rr = 3; m_sent = 0;
                exp_ack = '0; exp_done = '0; exp_req = 1'b0; exp_busy = 1'b0;
                m_q.delete();
            end else begin
                exp_ack = '0; exp_done = '0; exp_req = 1'b0;
                if (m_phase == 0) begin
                    if (src_req != '0) begin
                        c = 0;
                        for (int off = 1; off <= 4; off++) begin
                            c = (m_rr + off) % 4;
                            if (src_req[c]) break;
                        end
                        n = int'(src_length[c*4 +: 4]);
                        if (n > 8) n = 8;
                        m_q.delete();
                        m_q.push_back(8'h26);
                        m_q.push_back(8'h26);
                        if (TAG) m_q.push_back(8'h30 + 8'(c));
                        for (int b = 0; b < n; b++) m_q.push_back(src_payload[c*64 + b*8 +: 8]);
                        m_q.push_back(8'h26);
                        m_q.push_back(8'h26);
                        exp_ack[c] = 1'b1;
                        exp_req    = 1'b1;
                        exp_data   = m_q[0];
                        m_sent     = 1;
                        m_id       = c;
                        m_rr       = c;
                        m_phase    = 1;
                    end
                end else if (m_phase == 1) begin
                    if (byte_tx_done) begin
                        if (m_sent < m_q.size()) begin
                            exp_req  = 1'b1;
                            exp_data = m_q[m_sent];
                            m_sent++;
                        end else begin
                            exp_done[m_id] = 1'b1;
                            m_phase = 2;
                        end
                    end
                end else begin
                    m_phase = 0;
                end
                exp_busy = (m_phase != 0);
            end
        end
    end

    // Compare process and observation logs
    int done_src[4] = '{0, 0, 0, 0};
    int done_total = 0;
    int ack_log[$];
    bq_t tx_log;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                chk(src_ack == exp_ack, "src_ack", 64'(src_ack), 64'(exp_ack));
                chk(byte_tx_req == exp_req, "byte_tx_req", 64'(byte_tx_req), 64'(exp_req));
                if (exp_req) chk(byte_tx_data == exp_data, "byte_tx_data", 64'(byte_tx_data), 64'(exp_data));
                chk(src_done == exp_done, "src_done", 64'(src_done), 64'(exp_done));
                chk(busy == exp_busy, "busy", 64'(busy), 64'(exp_busy));
                for (int i = 0; i < 4; i++) begin
                    if (src_done[i]) begin done_src[i]++; done_total++; end
                    if (src_ack[i]) ack_log.push_back(i);
                end
            end
        end
    end

    // Byte transmitter model: done 1..4 cycles after each req
    bit spur_en = 1'b0;
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) cd = 0;
            else if (byte_tx_req) begin
                tx_log.push_back(byte_tx_data);
                cd = $urandom_range(1, 4);
            end
            @(posedge sys_clk);
            #2;
            byte_tx_done = 1'b0;
            if (!sys_rst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) byte_tx_done = 1'b1;
            end else if (spur_en && !busy && $urandom_range(0, 4) == 0) begin
                byte_tx_done = 1'b1;
            end
        end
    end

    // Source driver: every requester drops req in its ack cycle
    bit       rand_en = 1'b0;
    bit [3:0] rearm = '0;
    bit [3:0] reraise = '0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (src_ack[i]) begin
                src_req[i] = 1'b0;
                src_payload[i*64 +: 64] = {$urandom, $urandom};
                if (rearm[i]) reraise[i] = 1'b1;
            end else if (reraise[i]) begin
                src_req[i] = 1'b1;
                reraise[i] = 1'b0;
            end else if (rand_en && !src_req[i] && $urandom_range(0, 5) == 0) begin
                src_length[i*4 +: 4] = 4'($urandom_range(0, 15));
                src_payload[i*64 +: 64] = {$urandom, $urandom};
                src_req[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_total < target && t < 2000) begin tick(); t++; end
        if (t >= 2000) chk(1'b0, "wait_done_timeout", 64'(done_total), 64'(target));
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((busy || src_req != '0 || reraise != '0) && t < 5000) begin tick(); t++; end
        if (t >= 5000) chk(1'b0, "quiet_timeout", 64'(busy), 64'(0));
        tick(); tick();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({src_ack, src_done, busy, byte_tx_req, byte_tx_data} == 18'd0, name,
            64'({src_ack, src_done, busy, byte_tx_req, byte_tx_data}), 64'(0));
    endtask

    task automatic do_reset();
        tick();
        #2 sys_rst_n = 1'b0;
        #1 chk_outputs_zero("reset_outputs");
        tick(); tick();
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic chk_log(input string name, input bq_t e);
        chk(tx_log.size() == e.size(), {name, "_count"}, 64'(tx_log.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < tx_log.size(); i++)
            chk(tx_log[i] == e[i], name, 64'(tx_log[i]), 64'(e[i]));
    endtask

    initial begin
        bq_t e;
        int  d0, t;

        #1 chk_outputs_zero("power_on_reset");
        tick(); tick(); tick();
        #2 sys_rst_n = 1'b1;

        // Three-byte frame from source 0
        tx_log.delete();
        src_length[3:0] = 4'd3;
        src_payload[63:0] = 64'h0000_0000_0043_4241;
        tick();
        src_req[0] = 1'b1;
        wait_done(done_total + 1);
        e = '{8'h26, 8'h26, 8'h41, 8'h42, 8'h43, 8'h26, 8'h26};
        if (TAG) e.insert(2, 8'h30);
        chk_log("frame_src0", e);
        chk(done_src[0] == 1, "done_src0_once", 64'(done_src[0]), 64'(1));

        // All four held: grant order from reset is 0,1,2,3,0
        do_reset();
        ack_log.delete();
        src_length = 16'h2130;
        rearm = 4'hF;
        tick();
        src_req = 4'hF;
        t = 0;
        while (ack_log.size() < 5 && t < 3000) begin tick(); t++; end
        rearm = '0;
        wait_quiet();
        chk(ack_log.size() >= 5, "grant_count", 64'(ack_log.size()), 64'(5));
        if (ack_log.size() >= 5) begin
            chk(ack_log[0] == 0, "grant0", 64'(ack_log[0]), 64'(0));
            chk(ack_log[1] == 1, "grant1", 64'(ack_log[1]), 64'(1));
            chk(ack_log[2] == 2, "grant2", 64'(ack_log[2]), 64'(2));
            chk(ack_log[3] == 3, "grant3", 64'(ack_log[3]), 64'(3));
            chk(ack_log[4] == 0, "grant4", 64'(ack_log[4]), 64'(0));
        end

        // Zero-length frame from source 2
        tx_log.delete();
        d0 = done_src[2];
        src_length[11:8] = 4'd0;
        src_req[2] = 1'b1;
        wait_done(done_total + 1);
        e = '{8'h26, 8'h26, 8'h26, 8'h26};
        if (TAG) e.insert(2, 8'h32);
        chk_log("frame_len0", e);
        chk(done_src[2] == d0 + 1, "done_src2", 64'(done_src[2]), 64'(d0 + 1));

        // Length 15 clamps to 8 payload bytes
        tx_log.delete();
        src_length[7:4] = 4'd15;
        src_payload[127:64] = 64'h8877_6655_4433_2211;
        src_req[1] = 1'b1;
        wait_done(done_total + 1);
        e = '{8'h26, 8'h26, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h26, 8'h26};
        if (TAG) e.insert(2, 8'h31);
        chk_log("frame_clamp", e);

        // Reset in the middle of a source-0 payload
        tx_log.delete();
        src_length[3:0] = 4'd8;
        src_payload[63:0] = {$urandom, $urandom};
        src_req[0] = 1'b1;
        t = 0;
        while (tx_log.size() < 4 && t < 500) begin tick(); t++; end
        chk(tx_log.size() >= 4, "reach_data", 64'(tx_log.size()), 64'(4));
        d0 = done_total;
        tick();
        #2 sys_rst_n = 1'b0;
        #1 chk_outputs_zero("midframe_reset_outputs");
        tick(); tick(); tick();
        chk(done_total == d0, "no_done_after_abort", 64'(done_total), 64'(d0));
        #2 sys_rst_n = 1'b1;
        ack_log.delete();
        src_length[7:0] = 8'h11;
        tick();
        src_req[1:0] = 2'b11;
        t = 0;
        while (ack_log.size() < 1 && t < 100) begin tick(); t++; end
        chk(ack_log.size() >= 1, "post_reset_grant_seen", 64'(ack_log.size()), 64'(1));
        if (ack_log.size() >= 1) chk(ack_log[0] == 0, "post_reset_priority", 64'(ack_log[0]), 64'(0));
        wait_quiet();

        // Single byte from source 3 (tag 0x33 when enabled)
        tx_log.delete();
        src_length[15:12] = 4'd1;
        src_payload[255:192] = 64'h0000_0000_0000_005A;
        src_req[3] = 1'b1;
        wait_done(done_total + 1);
        e = '{8'h26, 8'h26, 8'h5A, 8'h26, 8'h26};
        if (TAG) e.insert(2, 8'h33);
        chk_log("frame_src3", e);

        // Random traffic with stray done pulses while idle
        rand_en = 1'b1;
        spur_en = 1'b1;
        repeat (4000) tick();
        rand_en = 1'b0;
        spur_en = 1'b0;
        wait_quiet();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
